imem_dmem_arbiter: RTL and testbench
====================================

Name: imem_dmem_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between the fetch stage (instruction reads) and the MEM stage (data loads/stores).
- Serves one access at a time.
- Data port has priority; a starvation counter guarantees fetch progress.
- Drives the pipeline stall indication used to hold the PC and IF/ID registers.

Parameters:
- MEM_LAT, 1: memory read latency in cycles (legal 1..7); mem_rdata_46 is valid MEM_LAT cycles after the mem_en_46 cycle.
- STARVE_MAX, 3: consecutive data grants allowed while a fetch request is pending before fetch wins a tie (0 = fetch always wins ties).

Ports:
- clk_46 in 1: clock, rising edge.
- rst_46 in 1: reset, asynchronous, active-high.
- if_req_46 in 1: fetch request; held until if_gnt_46.
- if_addr_46 in 32: fetch address.
- if_gnt_46 out 1: fetch grant pulse.
- if_rdata_46 out 32: fetched instruction.
- if_valid_46 out 1: fetch data valid pulse.
- if_stall_46 out 1: hold PC/IF-ID; equals if_req_46 & ~if_valid_46.
- dm_req_46 in 1: data request; held until dm_gnt_46.
- dm_we_46 in 1: 1 = store, 0 = load.
- dm_addr_46 in 32: data address.
- dm_wdata_46 in 32: store data.
- dm_gnt_46 out 1: data grant pulse.
- dm_rdata_46 out 32: load data.
- dm_valid_46 out 1: load data valid, or store-complete pulse.
- mem_en_46 out 1: memory access strobe.
- mem_we_46 out 1: memory write enable.
- mem_addr_46 out 32: memory address, bits [1:0] forced to 0.
- mem_wdata_46 out 32: memory write data.
- mem_rdata_46 in 32: memory read data.
- busy_46 out 1: high when state != IDLE.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Combinational arbitration. Data only -> data; fetch only -> fetch.
  - Both requesting: data wins unless starve_cnt == STARVE_MAX, then fetch wins.
  - Grant pulses high for exactly this cycle. Winner's addr/we/wdata and an owner bit are registered. Next state ISSUE. No request -> stay in IDLE.
- ISSUE (1 cycle): mem_en_46 = 1; mem_we_46/addr/wdata come from the registered values (mem_we_46 = 0 for fetch). Next state WAIT. A wait counter loads MEM_LAT.
- WAIT: decrement counter each cycle. On the edge where the counter reaches 1, capture mem_rdata_46 into the owner's rdata register (loads/fetches only), then go to RESP. Total: mem_rdata_46 is sampled exactly MEM_LAT cycles after the ISSUE cycle.
- RESP (1 cycle):
  - Owner's valid pulses high and the rdata register is stable.
  - Store: dm_valid_46 pulses high and dm_rdata_46 holds its previous value.
  - Next state IDLE. No arbitration occurs in RESP.
- Timing: grant at cycle T, mem_en at T+1, valid at T+2+MEM_LAT. Throughput is 1 access per MEM_LAT+3 cycles.
- if_rdata_46 and dm_rdata_46 hold their values until overwritten by the next owner access.
- Requests asserted while busy_46 = 1 are ignored until IDLE.
- Requesters must keep address/data stable only up to the grant cycle.
- starve_cnt (width sized to STARVE_MAX):
  - Increments when data is granted while if_req_46 = 1.
  - Saturates at STARVE_MAX.
  - Clears when fetch is granted.
  - Unchanged when data is granted with if_req_46 = 0.
- if_stall_46 is combinational and may be high in the same cycle as if_gnt_46.
- Reset, asynchronous, any state:
  - State -> IDLE.
  - All gnt, valid, mem_en_46 and mem_we_46 outputs -> 0.
  - mem_addr_46, mem_wdata_46, if_rdata_46, dm_rdata_46 -> 0.
  - starve_cnt -> 0; counter -> 0.
  - An in-flight access is abandoned; late memory data is ignored.
  - First grant is possible in the first cycle after deassertion.

Test Plan:
- Reset, then single fetch: if_req, addr 0x00000010, MEM_LAT=1 -> if_gnt at T; mem_en=1, mem_addr=0x10, mem_we=0 at T+1; if_valid=1 at T+3 with if_rdata = memory word; busy high T+1..T+3.
- Single store: dm_req, we=1, addr 0x00000103, wdata 0xDEADBEEF -> mem_addr=0x00000100, mem_we=1, mem_wdata=0xDEADBEEF for one cycle; dm_valid pulse; dm_rdata unchanged.
- Both requesters held continuously, STARVE_MAX=3 -> grant order D,D,D,F,D,D,D,F; every fetch completes.
- STARVE_MAX=0, both requesting -> fetch granted first every time.
- MEM_LAT=4, load at 0x20 -> mem_rdata sampled exactly 4 cycles after the mem_en cycle; dm_valid at T+6; a fetch request raised during WAIT is granted only in the following IDLE.
- Assert rst_46 during WAIT -> mem_en/valids drop immediately, state IDLE, rdata registers 0; after release a new fetch completes normally with correct data.

Source files
------------

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port fixed-latency memory between fetch and MEM-stage data ports.
// Grant at T, mem_en at T+1, valid at T+2+MEM_LAT; requests are held off while busy.
module imem_dmem_arbiter #(
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk_46,
  input  logic        rst_46,
  input  logic        if_req_46,
  input  logic [31:0] if_addr_46,
  output logic        if_gnt_46,
  output logic [31:0] if_rdata_46,
  output logic        if_valid_46,
  output logic        if_stall_46,
  input  logic        dm_req_46,
  input  logic        dm_we_46,
  input  logic [31:0] dm_addr_46,
  input  logic [31:0] dm_wdata_46,
  output logic        dm_gnt_46,
  output logic [31:0] dm_rdata_46,
  output logic        dm_valid_46,
  output logic        mem_en_46,
  output logic        mem_we_46,
  output logic [31:0] mem_addr_46,
  output logic [31:0] mem_wdata_46,
  input  logic [31:0] mem_rdata_46,
  output logic        busy_46
);
  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic          owner_dm;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [SW-1:0] starve_cnt;
  logic [2:0]    wait_cnt;
  logic          grant_if, grant_dm, fetch_first;

  always_comb begin
    state_nxt   = state;
    grant_if    = 1'b0;
    grant_dm    = 1'b0;
    fetch_first = if_req_46 && (starve_cnt == STARVE_LIM);
    case (state)
      IDLE: begin
        // Grants are suppressed while reset is held so none leak out combinationally.
        if (!rst_46) begin
          if (dm_req_46 && !fetch_first) grant_dm = 1'b1;
          else if (if_req_46)            grant_if = 1'b1;
        end
        if (grant_dm || grant_if) state_nxt = ISSUE;
      end
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_cnt == 3'd1) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_46 or posedge rst_46) begin
    if (rst_46) begin
      state       <= IDLE;
      owner_dm    <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
      if_rdata_46 <= '0;
      dm_rdata_46 <= '0;
    end else begin
      state <= state_nxt;
      if (grant_dm || grant_if) begin
        owner_dm <= grant_dm;
        we_q     <= grant_dm && dm_we_46;
        addr_q   <= grant_dm ? dm_addr_46 : if_addr_46;
      end
      if (grant_dm) wdata_q <= dm_wdata_46;

      if (grant_if)
        starve_cnt <= '0;
      else if (grant_dm && if_req_46 && (starve_cnt != STARVE_LIM))
        starve_cnt <= starve_cnt + SW'(1);

      if (state == ISSUE)     wait_cnt <= LAT_INIT;
      else if (state == WAIT) wait_cnt <= wait_cnt - 3'd1;

      // Read data lands in the owner's register on the last WAIT edge; stores leave both untouched.
      if (state == WAIT && wait_cnt == 3'd1 && !we_q) begin
        if (owner_dm) dm_rdata_46 <= mem_rdata_46;
        else          if_rdata_46 <= mem_rdata_46;
      end
    end
  end

  assign if_gnt_46    = grant_if;
  assign dm_gnt_46    = grant_dm;
  assign if_valid_46  = (state == RESP) && !owner_dm;
  assign dm_valid_46  = (state == RESP) && owner_dm;
  assign if_stall_46  = if_req_46 && !if_valid_46;
  assign mem_en_46    = (state == ISSUE);
  assign mem_we_46    = (state == ISSUE) && we_q;
  assign mem_addr_46  = addr_q & 32'hFFFF_FFFC;
  assign mem_wdata_46 = wdata_q;
  assign busy_46      = (state != IDLE);
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Three arbiter instances: [0] MEM_LAT=1/STARVE_MAX=3, [1] MEM_LAT=1/STARVE_MAX=0, [2] MEM_LAT=4/STARVE_MAX=3.
module tb_imem_dmem_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [2:0]       if_req, if_gnt, if_valid, if_stall;
  logic [2:0]       dm_req, dm_we, dm_gnt, dm_valid;
  logic [2:0]       mem_en, mem_we, busy;
  logic [2:0][31:0] if_addr, if_rdata, dm_addr, dm_wdata, dm_rdata;
  logic [2:0][31:0] mem_addr, mem_wdata, mem_rdata;

  logic [2:0][7:0]       pv = '0;
  logic [2:0][7:0][31:0] pd = '0;

  typedef struct {int g; bit dm; logic [31:0] data;} exp_t;
  exp_t sb[$];
  logic [31:0] last_dm [3];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 2) ? 4 : 1;
    localparam int SM  = (g == 1) ? 0 : 3;
    imem_dmem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SM)) u_dut (
      .clk_46(clk), .rst_46(rst),
      .if_req_46(if_req[g]), .if_addr_46(if_addr[g]), .if_gnt_46(if_gnt[g]),
      .if_rdata_46(if_rdata[g]), .if_valid_46(if_valid[g]), .if_stall_46(if_stall[g]),
      .dm_req_46(dm_req[g]), .dm_we_46(dm_we[g]), .dm_addr_46(dm_addr[g]),
      .dm_wdata_46(dm_wdata[g]), .dm_gnt_46(dm_gnt[g]), .dm_rdata_46(dm_rdata[g]),
      .dm_valid_46(dm_valid[g]), .mem_en_46(mem_en[g]), .mem_we_46(mem_we[g]),
      .mem_addr_46(mem_addr[g]), .mem_wdata_46(mem_wdata[g]), .mem_rdata_46(mem_rdata[g]),
      .busy_46(busy[g])
    );
    // Read data is only driven in its exact latency slot; anything else returns a poison word.
    assign mem_rdata[g] = pv[g][LAT-1] ? pd[g][LAT-1] : 32'hBAD0_BAD0;
  end

  // Memory model pipeline; deliberately not reset so late data keeps flowing.
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      pv[g][0] <= mem_en[g] && !mem_we[g];
      pd[g][0] <= mem_word(mem_addr[g]);
      for (int k = 1; k < 8; k++) begin
        pv[g][k] <= pv[g][k-1];
        pd[g][k] <= pd[g][k-1];
      end
    end
  end

  // Scoreboard: every valid pulse must match the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    logic [31:0] obs;
    if (!rst) begin
      for (int g = 0; g < 3; g++) begin
        if (if_valid[g] || dm_valid[g]) begin
          checks++;
          obs = dm_valid[g] ? dm_rdata[g] : if_rdata[g];
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid: inst %0d dm=%0d data %h, none expected", g, dm_valid[g], obs);
          end else begin
            e = sb.pop_front();
            if (e.g != g || e.dm != dm_valid[g] || obs !== e.data) begin
              errors++;
              $display("FAIL response: got inst %0d dm=%0d data %h, expected inst %0d dm=%0d data %h",
                       g, dm_valid[g], obs, e.g, e.dm, e.data);
            end
          end
        end
      end
    end
  end

  function automatic void push_exp(input int g, input bit dm, input bit we, input logic [31:0] addr);
    exp_t e;
    e.g = g;
    e.dm = dm;
    if (dm && we) e.data = last_dm[g];
    else e.data = mem_word(addr & 32'hFFFF_FFFC);
    if (dm && !we) last_dm[g] = e.data;
    sb.push_back(e);
  endfunction

  // Requests at the next negedge, holds until granted, drops after the grant edge.
  task automatic issue(input int g, input bit dm, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit expect_rsp);
    bit got = 0;
    @(negedge clk);
    if (dm) begin dm_req[g] = 1; dm_we[g] = we; dm_addr[g] = addr; dm_wdata[g] = wd; end
    else begin if_req[g] = 1; if_addr[g] = addr; end
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (dm ? dm_gnt[g] : if_gnt[g]) got = 1;
      else @(negedge clk);
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL grant_timeout: inst %0d dm=%0d got no grant, expected one", g, dm);
    end else if (expect_rsp) push_exp(g, dm, we, addr);
    @(negedge clk);
    if (dm) dm_req[g] = 0; else if_req[g] = 0;
  endtask

  task automatic wait_idle(input int g);
    bit idle = 0;
    for (int i = 0; i < 50 && !idle; i++) begin
      @(negedge clk); #1;
      if (!busy[g]) idle = 1;
    end
    checks++;
    if (!idle) begin errors++; $display("FAIL idle_timeout: inst %0d busy=1, expected 0", g); end
  endtask

  task automatic test_reset();
    rst = 1; if_req = '0; dm_req = '0; dm_we = '0;
    if_addr = '0; dm_addr = '0; dm_wdata = '0;
    for (int g = 0; g < 3; g++) last_dm[g] = '0;
    repeat (2) @(negedge clk);
    if_req[0] = 1; if_addr[0] = 32'h10;
    #1;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({if_gnt[g], dm_gnt[g], if_valid[g], dm_valid[g], mem_en[g], mem_we[g], busy[g]} !== 7'b0) begin
        errors++; $display("FAIL reset_ctrl: inst %0d got %b, expected 0", g,
          {if_gnt[g], dm_gnt[g], if_valid[g], dm_valid[g], mem_en[g], mem_we[g], busy[g]});
      end
      checks++;
      if ({mem_addr[g], mem_wdata[g], if_rdata[g], dm_rdata[g]} !== 128'b0) begin
        errors++; $display("FAIL reset_data: inst %0d got %h, expected 0", g,
          {mem_addr[g], mem_wdata[g], if_rdata[g], dm_rdata[g]});
      end
    end
    if_req[0] = 0;
    @(negedge clk);
    rst = 0;
  endtask

  // Starts in the first cycle after reset release.
  task automatic test_single_fetch();
    if_req[0] = 1; if_addr[0] = 32'h0000_0010;
    #1;
    checks++;
    if (!if_gnt[0] || !if_stall[0] || busy[0]) begin
      errors++; $display("FAIL fetch_grant: gnt/stall/busy %b%b%b, expected 110", if_gnt[0], if_stall[0], busy[0]);
    end
    push_exp(0, 0, 0, 32'h10);
    @(negedge clk); if_req[0] = 0; #1;
    checks++;
    if (!mem_en[0] || mem_we[0] || mem_addr[0] !== 32'h10 || !busy[0] || if_gnt[0]) begin
      errors++; $display("FAIL fetch_issue: en/we %b%b addr %h busy %b, expected 10 00000010 1",
                         mem_en[0], mem_we[0], mem_addr[0], busy[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_en[0] || if_valid[0] || !busy[0]) begin
      errors++; $display("FAIL fetch_wait: en/valid/busy %b%b%b, expected 001", mem_en[0], if_valid[0], busy[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (!if_valid[0] || if_rdata[0] !== mem_word(32'h10) || !busy[0]) begin
      errors++; $display("FAIL fetch_resp: valid %b data %h, expected 1 %h", if_valid[0], if_rdata[0], mem_word(32'h10));
    end
    @(negedge clk); #1;
    checks++;
    if (busy[0] || if_valid[0]) begin
      errors++; $display("FAIL fetch_done: busy/valid %b%b, expected 00", busy[0], if_valid[0]);
    end
  endtask

  task automatic test_single_store();
    issue(0, 1, 0, 32'h40, 32'h0, 1);
    wait_idle(0);
    @(negedge clk);
    dm_req[0] = 1; dm_we[0] = 1; dm_addr[0] = 32'h0000_0103; dm_wdata[0] = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (!dm_gnt[0]) begin errors++; $display("FAIL store_grant: got 0, expected 1"); end
    push_exp(0, 1, 1, 32'h103);
    @(negedge clk); dm_req[0] = 0; dm_we[0] = 0; #1;
    checks++;
    if (!mem_en[0] || !mem_we[0] || mem_addr[0] !== 32'h100 || mem_wdata[0] !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL store_issue: en/we %b%b addr %h wdata %h, expected 11 00000100 deadbeef",
                         mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    end
    @(negedge clk); #1;
    checks++;
    if (mem_en[0] || mem_we[0]) begin errors++; $display("FAIL store_we_width: en/we %b%b, expected 00", mem_en[0], mem_we[0]); end
    @(negedge clk); #1;
    checks++;
    if (!dm_valid[0] || dm_rdata[0] !== mem_word(32'h40)) begin
      errors++; $display("FAIL store_resp: valid %b rdata %h, expected 1 %h", dm_valid[0], dm_rdata[0], mem_word(32'h40));
    end
    wait_idle(0);
  endtask

  task automatic run_both(input int g, input int n, input string order, input logic [31:0] base);
    int k = 0;
    byte who;
    bit bump_if, bump_dm;
    @(negedge clk);
    if_req[g] = 1; dm_req[g] = 1; dm_we[g] = 0;
    if_addr[g] = base; dm_addr[g] = base + 32'h100;
    for (int c = 0; c < 400 && k < n; c++) begin
      #1;
      bump_if = 0; bump_dm = 0;
      if (dm_gnt[g] || if_gnt[g]) begin
        who = dm_gnt[g] ? "D" : "F";
        checks++;
        if (who != order[k]) begin
          errors++; $display("FAIL grant_order: inst %0d grant %0d got %c, expected %c", g, k, who, order[k]);
        end
        if (dm_gnt[g]) begin push_exp(g, 1, 0, dm_addr[g]); bump_dm = 1; end
        else begin push_exp(g, 0, 0, if_addr[g]); bump_if = 1; end
        k++;
      end
      @(negedge clk);
      if (bump_if) if_addr[g] = if_addr[g] + 4;
      if (bump_dm) dm_addr[g] = dm_addr[g] + 4;
    end
    checks++;
    if (k != n) begin errors++; $display("FAIL grant_count: inst %0d got %0d grants, expected %0d", g, k, n); end
    if_req[g] = 0; dm_req[g] = 0;
    wait_idle(g);
  endtask

  task automatic test_starvation();
    run_both(0, 8, "DDDFDDDF", 32'h200);
  endtask

  task automatic test_fetch_priority();
    run_both(1, 4, "FFFF", 32'h600);
    issue(1, 1, 0, 32'h700, 32'h0, 1);
    wait_idle(1);
  endtask

  task automatic test_mem_lat4();
    issue(2, 1, 0, 32'h20, 32'h0, 1);
    #1;
    checks++;
    if (!mem_en[2] || mem_we[2] || mem_addr[2] !== 32'h20) begin
      errors++; $display("FAIL lat4_issue: en/we %b%b addr %h, expected 10 00000020", mem_en[2], mem_we[2], mem_addr[2]);
    end
    for (int c = 2; c <= 7; c++) begin
      @(negedge clk);
      if (c == 3) begin if_req[2] = 1; if_addr[2] = 32'h30; end
      #1;
      checks++;
      if (dm_valid[2] !== (c == 6)) begin
        errors++; $display("FAIL lat4_valid_time: cycle T+%0d dm_valid %b, expected %b", c, dm_valid[2], c == 6);
      end
      if (c >= 3) begin
        checks++;
        if (if_gnt[2] !== (c == 7)) begin
          errors++; $display("FAIL lat4_busy_gnt: cycle T+%0d if_gnt %b, expected %b", c, if_gnt[2], c == 7);
        end
      end
      if (c == 4) begin
        checks++;
        if (!if_stall[2]) begin errors++; $display("FAIL lat4_stall: got 0, expected 1"); end
      end
      if (c == 6) begin
        checks++;
        if (dm_rdata[2] !== mem_word(32'h20)) begin
          errors++; $display("FAIL lat4_data: got %h, expected %h", dm_rdata[2], mem_word(32'h20));
        end
      end
    end
    push_exp(2, 0, 0, 32'h30);
    @(negedge clk); if_req[2] = 0;
    wait_idle(2);
  endtask

  task automatic test_reset_in_wait();
    issue(2, 0, 0, 32'h44, 32'h0, 0);
    @(negedge clk); @(negedge clk); #1;
    rst = 1; #1;
    checks++;
    if ({mem_en[2], mem_we[2], if_valid[2], dm_valid[2], busy[2]} !== 5'b0) begin
      errors++; $display("FAIL rst_wait_ctrl: en/we/iv/dv/busy %b, expected 0",
                         {mem_en[2], mem_we[2], if_valid[2], dm_valid[2], busy[2]});
    end
    checks++;
    if (if_rdata[2] !== 32'h0 || dm_rdata[2] !== 32'h0 || if_rdata[0] !== 32'h0) begin
      errors++; $display("FAIL rst_wait_rdata: if %h dm %h if0 %h, expected 0", if_rdata[2], dm_rdata[2], if_rdata[0]);
    end
    for (int g = 0; g < 3; g++) last_dm[g] = '0;
    @(negedge clk); rst = 0;
    repeat (4) @(negedge clk);
    issue(2, 0, 0, 32'h48, 32'h0, 1);
    wait_idle(2);
    checks++;
    if (if_rdata[2] !== mem_word(32'h48)) begin
      errors++; $display("FAIL rst_recover: got %h, expected %h", if_rdata[2], mem_word(32'h48));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_single_store();
    test_starvation();
    test_fetch_priority();
    test_mem_lat4();
    test_reset_in_wait();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL leftover: %0d responses outstanding, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
